// File: rtl/ram8_bank.sv
// ram8_bank: 8-word register bank with a one-hot load demux, a combinational read mux
// and a self-sequenced clear sweep. Optional per-word parity is enabled with RAM8_PARITY_EN.
module ram8_bank #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    input  logic [2:0]       address,
    input  logic             clear_req,
`ifdef RAM8_PARITY_EN
    input  logic             inject_err,
    output logic             parity_err,
`endif
    output logic [WIDTH-1:0] out,
    output logic             busy,
    output logic             clear_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       ptr_q, ptr_d;
    logic             busy_q, busy_d;
    logic             clear_done_q, clear_done_d;
    logic [WIDTH-1:0] word_q [8];
    logic [WIDTH-1:0] word_d [8];
    logic [7:0]       load_sel;
`ifdef RAM8_PARITY_EN
    logic [7:0]       par_q, par_d;
`endif

    // Writes are only accepted in IDLE, and a same-edge clear request wins over a load.
    always_comb begin
        load_sel = 8'b0;
        load_sel[address] = load & (state_q == IDLE) & ~clear_req;
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        busy_d       = busy_q;
        clear_done_d = 1'b0;
        word_d       = word_q;
`ifdef RAM8_PARITY_EN
        par_d        = par_q;
`endif
        for (int i = 0; i < 8; i++) begin
            if (load_sel[i]) begin
                word_d[i] = in;
`ifdef RAM8_PARITY_EN
                par_d[i]  = (^in) ^ inject_err;
`endif
            end
        end
        case (state_q)
            IDLE: begin
                if (clear_req) begin
                    state_d = CLEAR;
                    ptr_d   = 3'd0;
                    busy_d  = 1'b1;
                end
            end
            CLEAR: begin
                word_d[ptr_q] = '0;
`ifdef RAM8_PARITY_EN
                par_d[ptr_q]  = 1'b0;
`endif
                ptr_d = ptr_q + 3'd1;
                if (ptr_q == 3'd7) begin
                    state_d      = DONE;
                    busy_d       = 1'b0;
                    clear_done_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            ptr_q        <= 3'd0;
            busy_q       <= 1'b0;
            clear_done_q <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                word_q[i] <= '0;
            end
`ifdef RAM8_PARITY_EN
            par_q        <= 8'b0;
`endif
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            busy_q       <= busy_d;
            clear_done_q <= clear_done_d;
            for (int i = 0; i < 8; i++) begin
                word_q[i] <= word_d[i];
            end
`ifdef RAM8_PARITY_EN
            par_q        <= par_d;
`endif
        end
    end

    assign out        = word_q[address];
    assign busy       = busy_q;
    assign clear_done = clear_done_q;
`ifdef RAM8_PARITY_EN
    assign parity_err = (^word_q[address]) != par_q[address];
`endif

endmodule
